// File: rtl/picobus_fifo_slave.sv
// PicoBus target with ID/CTRL/STATUS/SCRATCH registers and 128-bit TX/RX FIFO data ports.
// Optional build macro PICOBUS_FIFO_LOOPBACK_EN adds CTRL.LOOPBACK (TX head feeds the RX FIFO).
module picobus_fifo_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter logic [31:0] ID_VALUE   = 32'h5046_0001,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic         PicoClk,
    input  logic         PicoRst,
    input  logic [31:0]  PicoAddr,
    input  logic         PicoWr,
    input  logic [127:0] PicoDataIn,
    input  logic         PicoRd,
    output logic [127:0] PicoDataOut,
    output logic         tx_valid,
    input  logic         tx_rdy,
    output logic [127:0] tx_data,
    input  logic         rx_valid,
    output logic         rx_rdy,
    input  logic [127:0] rx_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

    localparam logic [3:0] OFF_ID      = 4'd0;
    localparam logic [3:0] OFF_CTRL    = 4'd1;
    localparam logic [3:0] OFF_STATUS  = 4'd2;
    localparam logic [3:0] OFF_SCRATCH = 4'd3;
    localparam logic [3:0] OFF_TXDATA  = 4'd4;
    localparam logic [3:0] OFF_RXDATA  = 4'd5;

    logic [127:0]          tx_mem [DEPTH];
    logic [127:0]          rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0]         tx_count, rx_count;
    logic                  tx_overflow, rx_underflow;
    logic [127:0]          scratch;
    logic                  loop_en;
    logic                  lb_xfer;
    logic [127:0]          rx_push_data;
    logic [127:0]          rdata_next;

    logic       hit, bus_wr, bus_rd, flush, status_wr;
    logic [3:0] offset;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic       rx_pop_req, rx_push, rx_pop, rx_unf_set;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^PicoAddr[3:0];

    assign hit       = (PicoAddr[31:8] == BASE_ADDR[31:8]);
    assign offset    = PicoAddr[7:4];
    assign bus_wr    = hit && PicoWr;
    assign bus_rd    = hit && PicoRd;
    assign flush     = bus_wr && (offset == OFF_CTRL) && PicoDataIn[0];
    assign status_wr = bus_wr && (offset == OFF_STATUS);

    assign tx_full  = (tx_count == CNT_FULL);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CNT_FULL);
    assign rx_empty = (rx_count == '0);

`ifdef PICOBUS_FIFO_LOOPBACK_EN
    assign lb_xfer      = loop_en && !tx_empty && !rx_full && !flush;
    assign rx_push_data = lb_xfer ? tx_mem[tx_rptr] : rx_data;
`else
    assign loop_en      = 1'b0;
    assign lb_xfer      = 1'b0;
    assign rx_push_data = rx_data;
`endif

    assign tx_valid = !loop_en && !tx_empty;
    assign tx_data  = tx_mem[tx_rptr];
    assign rx_rdy   = !PicoRst && !loop_en && !rx_full;

    // Flush overrides every push and pop in the same cycle, including stream handshakes.
    assign tx_pop      = !flush && ((tx_valid && tx_rdy) || lb_xfer);
    assign tx_push_req = bus_wr && (offset == OFF_TXDATA);
    assign tx_push     = !flush && tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_set  = !flush && tx_push_req && tx_full && !tx_pop;

    assign rx_push    = !flush && ((rx_valid && rx_rdy) || lb_xfer);
    assign rx_pop_req = bus_rd && (offset == OFF_RXDATA);
    assign rx_pop     = !flush && rx_pop_req && !rx_empty;
    assign rx_unf_set = !flush && rx_pop_req && rx_empty;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rdata_next = '0;
        if (bus_rd) begin
            case (offset)
                OFF_ID: begin
                    rdata_next[31:0]  = ID_VALUE;
                    rdata_next[39:32] = 8'(DEPTH_LOG2);
                end
                OFF_CTRL:    rdata_next[1] = loop_en;
                OFF_STATUS: begin
                    rdata_next[15:0]  = 16'(tx_count);
                    rdata_next[31:16] = 16'(rx_count);
                    rdata_next[32]    = tx_full;
                    rdata_next[33]    = tx_empty;
                    rdata_next[34]    = rx_full;
                    rdata_next[35]    = rx_empty;
                    rdata_next[36]    = tx_overflow;
                    rdata_next[37]    = rx_underflow;
                end
                OFF_SCRATCH: rdata_next = scratch;
                OFF_RXDATA:  rdata_next = rx_empty ? '0 : rx_mem[rx_rptr];
                default:     rdata_next = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge PicoClk) begin
        if (PicoRst) begin
            PicoDataOut  <= '0;
            tx_wptr      <= '0;
            tx_rptr      <= '0;
            tx_count     <= '0;
            rx_wptr      <= '0;
            rx_rptr      <= '0;
            rx_count     <= '0;
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
            scratch      <= '0;
        end else begin
            PicoDataOut <= rdata_next;
            if (flush) begin
                tx_wptr      <= '0;
                tx_rptr      <= '0;
                tx_count     <= '0;
                rx_wptr      <= '0;
                rx_rptr      <= '0;
                rx_count     <= '0;
                tx_overflow  <= 1'b0;
                rx_underflow <= 1'b0;
            end else begin
                if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
                if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
                if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
                if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
                tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
                rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);

                if (tx_ovf_set)                        tx_overflow <= 1'b1;
                else if (status_wr && PicoDataIn[36])  tx_overflow <= 1'b0;
                if (rx_unf_set)                        rx_underflow <= 1'b1;
                else if (status_wr && PicoDataIn[37])  rx_underflow <= 1'b0;
            end
            if (bus_wr && (offset == OFF_SCRATCH)) scratch <= PicoDataIn;
        end
    end

`ifdef PICOBUS_FIFO_LOOPBACK_EN
    always_ff @(posedge PicoClk) begin
        if (PicoRst)                                loop_en <= 1'b0;
        else if (bus_wr && (offset == OFF_CTRL))    loop_en <= PicoDataIn[1];
    end
`endif

    // NOTE: FIFO storage is not reset; pointers and counts alone define which entries are valid.
    always_ff @(posedge PicoClk) begin
        if (tx_push) tx_mem[tx_wptr] <= PicoDataIn;
        if (rx_push) rx_mem[rx_wptr] <= rx_push_data;
    end

endmodule

// File: tb/tb_picobus_fifo_slave.sv
// Scoreboard bench for picobus_fifo_slave: bus reads and TX stream words are predicted and compared.
// Loopback checks are compiled when PICOBUS_FIFO_LOOPBACK_EN is defined.
module tb_picobus_fifo_slave;
    localparam logic [31:0] BASE      = 32'h0001_0000;
    localparam logic [31:0] A_ID      = BASE + 32'h00;
    localparam logic [31:0] A_CTRL    = BASE + 32'h10;
    localparam logic [31:0] A_STATUS  = BASE + 32'h20;
    localparam logic [31:0] A_SCRATCH = BASE + 32'h30;
    localparam logic [31:0] A_TX      = BASE + 32'h40;
    localparam logic [31:0] A_RX      = BASE + 32'h50;
    localparam logic [31:0] A_UNMAP   = BASE + 32'h90;
    localparam logic [31:0] A_OUTSIDE = 32'h0002_0030;
    localparam logic [127:0] PAT_A5   = {16{8'hA5}};

    logic         PicoClk;
    logic         PicoRst;
    logic [31:0]  PicoAddr;
    logic         PicoWr;
    logic [127:0] PicoDataIn;
    logic         PicoRd;
    logic [127:0] PicoDataOut;
    logic         tx_valid;
    logic         tx_rdy;
    logic [127:0] tx_data;
    logic         rx_valid;
    logic         rx_rdy;
    logic [127:0] rx_data;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 0;
    bit rd_q = 0;
    bit loopback_mode = 0;

    string        tag_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] tx_exp[$];
    logic [127:0] rx_model[$];

    picobus_fifo_slave dut (
        .PicoClk    (PicoClk),
        .PicoRst    (PicoRst),
        .PicoAddr   (PicoAddr),
        .PicoWr     (PicoWr),
        .PicoDataIn (PicoDataIn),
        .PicoRd     (PicoRd),
        .PicoDataOut(PicoDataOut),
        .tx_valid   (tx_valid),
        .tx_rdy     (tx_rdy),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data)
    );

    initial PicoClk = 1'b0;
    always #5 PicoClk = ~PicoClk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] status_word(input int txc, input int rxc, input bit ovf, input bit unf);
        logic [127:0] w;
        w        = '0;
        w[15:0]  = 16'(txc);
        w[31:16] = 16'(rxc);
        w[32]    = (txc == 16);
        w[33]    = (txc == 0);
        w[34]    = (rxc == 16);
        w[35]    = (rxc == 0);
        w[36]    = ovf;
        w[37]    = unf;
        return w;
    endfunction

    // Tracks which cycles must carry read data; all others must show zero.
    always @(posedge PicoClk) rd_q <= PicoRd && !PicoRst;

    always @(negedge PicoClk) begin
        if (mon_en) begin
            if (rd_q) begin
                if (exp_q.size() == 0) begin
                    check("sb_underrun", 128'(exp_q.size()), 128'(1));
                end else begin
                    check(tag_q.pop_front(), PicoDataOut, exp_q.pop_front());
                end
            end else begin
                check("idle_zero", PicoDataOut, '0);
            end
            if (tx_valid === 1'b1 && tx_rdy) begin
                if (tx_exp.size() == 0) check("tx_unexpected", 128'(tx_exp.size()), 128'(1));
                else                    check("tx_stream", tx_data, tx_exp.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [127:0] d);
        PicoAddr = addr; PicoDataIn = d; PicoWr = 1'b1;
        @(posedge PicoClk); #1;
        PicoWr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [127:0] exp, input string tag);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        PicoAddr = addr; PicoRd = 1'b1;
        @(posedge PicoClk); #1;
        PicoRd = 1'b0;
    endtask

    task automatic tx_write(input logic [127:0] d);
        if (loopback_mode) rx_model.push_back(d);
        else if (tx_exp.size() < 16 || tx_rdy) tx_exp.push_back(d);
        bus_write(A_TX, d);
    endtask

    task automatic rx_send(input logic [127:0] d);
        check("rx_rdy_before_send", 128'(rx_rdy), 128'(1));
        rx_valid = 1'b1; rx_data = d; rx_model.push_back(d);
        @(posedge PicoClk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic rx_read();
        logic [127:0] e;
        e = (rx_model.size() > 0) ? rx_model.pop_front() : '0;
        bus_read(A_RX, e, "rx_data");
    endtask

    task automatic wait_tx_drain();
        for (int i = 0; i < 100 && tx_exp.size() > 0; i++) @(posedge PicoClk);
        #1;
        check("tx_drain_budget", 128'(tx_exp.size()), 128'(0));
    endtask

    task automatic do_reset();
        PicoRst = 1'b1;
        repeat (2) @(posedge PicoClk);
        #1;
        mon_en = 1'b1;
        check("rst_dataout", PicoDataOut, '0);
        check("rst_tx_valid", 128'(tx_valid), 128'(0));
        check("rst_rx_rdy", 128'(rx_rdy), 128'(0));
        PicoRst = 1'b0;
        tx_exp.delete();
        rx_model.delete();
        @(posedge PicoClk); #1;
        check("post_rst_rx_rdy", 128'(rx_rdy), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [127:0] id_exp;
        PicoRst = 1'b1; PicoAddr = '0; PicoWr = 1'b0; PicoDataIn = '0; PicoRd = 1'b0;
        tx_rdy = 1'b0; rx_valid = 1'b0; rx_data = '0;
        do_reset();

        // Identity and post-reset status.
        id_exp = '0;
        id_exp[31:0]  = 32'h5046_0001;
        id_exp[39:32] = 8'd4;
        bus_read(A_ID, id_exp, "id");
        bus_read(A_STATUS, status_word(0, 0, 0, 0), "status_reset");
        bus_read(A_CTRL, '0, "ctrl_reset");
        bus_read(A_SCRATCH, '0, "scratch_reset");

        // Scratch write visible to the very next read.
        bus_write(A_SCRATCH, PAT_A5);
        bus_read(A_SCRATCH, PAT_A5, "scratch_rw");
        repeat (2) @(posedge PicoClk);
        #1;

        // Out-of-window and unmapped accesses.
        bus_write(A_OUTSIDE, 128'h1234);
        bus_read(A_OUTSIDE, '0, "outside_read");
        bus_read(A_SCRATCH, PAT_A5, "scratch_untouched");
        bus_read(A_UNMAP, '0, "unmapped_read");
        bus_read(A_TX, '0, "txdata_read_zero");

        // Fill TX past full with the stream stalled.
        for (int i = 0; i < 17; i++) begin
            tx_write(128'hC0DE_0000 + 128'(i));
            if (i == 0) check("tx_valid_after_push", 128'(tx_valid), 128'(1));
        end
        bus_read(A_STATUS, status_word(16, 0, 1, 0), "status_tx_overflow");
        bus_write(A_STATUS, 128'(1) << 36);
        bus_read(A_STATUS, status_word(16, 0, 0, 0), "status_ovf_cleared");
        tx_rdy = 1'b1;
        wait_tx_drain();
        check("tx_valid_drained", 128'(tx_valid), 128'(0));
        tx_rdy = 1'b0;

        // RX stream in, back-to-back reads out with one underflow.
        for (int i = 0; i < 3; i++) rx_send(128'hBEEF_0000 + 128'(i));
        for (int i = 0; i < 4; i++) rx_read();
        bus_read(A_STATUS, status_word(0, 0, 0, 1), "status_rx_underflow");

        // Flush with both FIFOs half full and a sticky set.
        for (int i = 0; i < 8; i++) tx_write(128'hF1F0_0000 + 128'(i));
        for (int i = 0; i < 8; i++) rx_send(128'hF2F0_0000 + 128'(i));
        bus_read(A_STATUS, status_word(8, 8, 0, 1), "status_half_full");
        bus_write(A_CTRL, 128'h1);
        tx_exp.delete();
        rx_model.delete();
        bus_read(A_STATUS, status_word(0, 0, 0, 0), "status_after_flush");
        bus_read(A_CTRL, '0, "ctrl_after_flush");
        check("tx_valid_after_flush", 128'(tx_valid), 128'(0));

        // Full TX FIFO with a same-cycle pop and push: both accepted, no overflow.
        for (int i = 0; i < 16; i++) tx_write(128'hAB00_0000 + 128'(i));
        tx_rdy = 1'b1;
        tx_write(128'hAB00_FFFF);
        wait_tx_drain();
        bus_read(A_STATUS, status_word(0, 0, 0, 0), "status_full_pushpop");

        // Fill RX to full: rx_rdy drops, count reads 16.
        for (int i = 0; i < 16; i++) rx_send(128'hDD00_0000 + 128'(i));
        check("rx_rdy_full", 128'(rx_rdy), 128'(0));
        bus_read(A_STATUS, status_word(0, 16, 0, 0), "status_rx_full");
        for (int i = 0; i < 16; i++) rx_read();
        bus_read(A_STATUS, status_word(0, 0, 0, 0), "status_rx_drained");

`ifdef PICOBUS_FIFO_LOOPBACK_EN
        bus_write(A_CTRL, 128'h2);
        bus_read(A_CTRL, 128'h2, "ctrl_loopback");
        loopback_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_write(128'h1B00_0000 + 128'(i));
            check("lb_tx_valid_low", 128'(tx_valid), 128'(0));
            check("lb_rx_rdy_low", 128'(rx_rdy), 128'(0));
        end
        repeat (3) @(posedge PicoClk);
        #1;
        for (int i = 0; i < 5; i++) rx_read();
        loopback_mode = 1'b0;
        bus_write(A_CTRL, 128'h0);
        bus_read(A_STATUS, status_word(0, 0, 0, 0), "status_after_loopback");
`else
        bus_write(A_CTRL, 128'h2);
        bus_read(A_CTRL, '0, "ctrl_loopback_absent");
`endif

        // Reset arriving together with an RX read: no data returned.
        rx_send(128'h5151);
        PicoAddr = A_RX; PicoRd = 1'b1; PicoRst = 1'b1;
        @(posedge PicoClk); #1;
        PicoRd = 1'b0;
        check("rst_with_read_dout", PicoDataOut, '0);
        @(posedge PicoClk); #1;
        PicoRst = 1'b0;
        rx_model.delete();
        tx_exp.delete();
        bus_read(A_STATUS, status_word(0, 0, 0, 0), "status_after_rst_read");

        repeat (3) @(posedge PicoClk);
        #1;
        check("sb_leftover", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
